csr_bank: RTL and testbench

//  Parametrised control/status register bank behind the SPI slave command decoder.

---
 rtl/csr_bank_pkg.sv | 26 ++
 rtl/csr_reg.sv | 54 +++++
 rtl/csr_bank.sv | 123 ++++++++++++
 tb/tb_csr_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_bank_pkg.sv
// csr_bank shared types: access kinds, mask helper, byte-enable width.
// Masks are passed zero-extended to MAX_REG bits.
package csr_bank_pkg;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } csr_acc_e;

  localparam int MAX_REG    = 128;
  localparam int DWIDTH_DEF = 32;
  localparam int BE_W       = DWIDTH_DEF / 8;

  // RO wins over W1C when both mask bits are set
  function automatic csr_acc_e acc_of(
    input int                 i,
    input logic [MAX_REG-1:0] ro,
    input logic [MAX_REG-1:0] w1c
  );
    if (ro[i])  return ACC_RO;
    if (w1c[i]) return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/csr_reg.sv
// csr_bank single register: RW byte writes, W1C clear with sticky
// event set (set wins), or constant RO storage.
module csr_reg
  import csr_bank_pkg::*;
#(
  parameter int                DWIDTH  = 32,
  parameter logic [DWIDTH-1:0] RST_VAL = '0,
  parameter csr_acc_e          ACC     = ACC_RW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DWIDTH-1:0]     din_i,
  input  logic [DWIDTH/8-1:0]   be_i,
  input  logic [DWIDTH-1:0]     evt_i,
  output logic [DWIDTH-1:0]     q_o
);

  logic [DWIDTH-1:0] q_q;
  logic [DWIDTH-1:0] q_d;
  logic [DWIDTH-1:0] bmask;
  logic [DWIDTH-1:0] rw_d;
  logic [DWIDTH-1:0] w1c_d;

  always_comb begin
    bmask = '0;
    for (int k = 0; k < DWIDTH / 8; k++) begin
      bmask[k*8 +: 8] = {8{be_i[k]}};
    end
  end

  assign rw_d  = we_i ? ((q_q & ~bmask) | (din_i & bmask)) : q_q;
  assign w1c_d = (q_q & ~(we_i ? (din_i & bmask) : '0)) | evt_i;

  always_comb begin
    q_d = q_q;
    unique case (ACC)
      ACC_RW:  q_d = rw_d;
      ACC_W1C: q_d = w1c_d;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/csr_bank.sv
// csr_bank top: decode, registered read path, error pulse, optional irq.
// Define CSR_BANK_IRQ_EN to build the W1C-driven interrupt.
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter int                         DWIDTH   = 32,
  parameter int                         NUM_REG  = 16,
  parameter int                         ALINES   = 7,
  parameter logic [DWIDTH*NUM_REG-1:0]  RST_VAL  = '0,
  parameter logic [NUM_REG-1:0]         RO_MASK  = '0,
  parameter logic [NUM_REG-1:0]         W1C_MASK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [ALINES-1:0]           addr,
  input  logic [DWIDTH-1:0]           din,
  input  logic [DWIDTH/8-1:0]         be,
  input  logic [DWIDTH*NUM_REG-1:0]   dfbck,
  input  logic [DWIDTH*NUM_REG-1:0]   evt,
  output logic [DWIDTH*NUM_REG-1:0]   regdata,
  output logic [NUM_REG-1:0]          decd,
  output logic [DWIDTH-1:0]           dout,
  output logic                        dout_vld,
  output logic                        err,
  output logic                        irq
);

  localparam logic [MAX_REG-1:0] RO_X  = MAX_REG'(RO_MASK);
  localparam logic [MAX_REG-1:0] W1C_X = MAX_REG'(W1C_MASK) & ~RO_X;

  logic              hit;
  logic              rd_v;
  logic              ro_sel;
  logic              err_d;
  logic [DWIDTH-1:0] rdata;
  logic [DWIDTH-1:0] dout_q;
  logic              vld_q;
  logic              err_q;

  assign hit  = {1'b0, addr} < (ALINES+1)'(NUM_REG);
  assign rd_v = cs & rd;

  for (genvar i = 0; i < NUM_REG; i++) begin : g_reg
    assign decd[i] = cs && (addr == ALINES'(i));

    csr_reg #(
      .DWIDTH  (DWIDTH),
      .RST_VAL (RST_VAL[i*DWIDTH +: DWIDTH]),
      .ACC     (acc_of(i, RO_X, W1C_X))
    ) u_reg (
      .clk   (clk),
      .rst   (rst),
      .we_i  (decd[i] & wr),
      .din_i (din),
      .be_i  (be),
      .evt_i (evt[i*DWIDTH +: DWIDTH]),
      .q_o   (regdata[i*DWIDTH +: DWIDTH])
    );
  end

  // decd is one-hot or zero, so rdata is 0 for out-of-range reads
  always_comb begin
    rdata  = '0;
    ro_sel = 1'b0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (decd[i]) begin
        rdata  = RO_X[i] ? dfbck[i*DWIDTH +: DWIDTH]
                         : regdata[i*DWIDTH +: DWIDTH];
        ro_sel = RO_X[i];
      end
    end
  end

  assign err_d = cs & (((wr | rd) & ~hit) | (wr & ro_sel));

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= rd_v;
      err_q <= err_d;
      if (rd_v) begin
        dout_q <= rdata;
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign err      = err_q;

`ifdef CSR_BANK_IRQ_EN
  logic irq_q;
  logic irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (W1C_X[i]) begin
        irq_d = irq_d | (|regdata[i*DWIDTH +: DWIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_bank.sv
// csr_bank bench: directed scenarios plus random traffic checked
// against a per-register behavioural model.
module tb_csr_bank;
  import csr_bank_pkg::*;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AL = 7;
  localparam logic [DW*NR-1:0] RV =
    {{((NR-2)*DW){1'b0}}, 32'h5AA55AA5, 32'h0};
  localparam logic [NR-1:0] ROM = 16'h0030;
  localparam logic [NR-1:0] W1M = 16'h0068;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cs = 1'b0;
  logic               wr = 1'b0;
  logic               rd = 1'b0;
  logic [AL-1:0]      addr = '0;
  logic [DW-1:0]      din = '0;
  logic [BE_W-1:0]    be = '0;
  logic [DW*NR-1:0]   dfbck = '0;
  logic [DW*NR-1:0]   evt = '0;
  logic [DW*NR-1:0]   regdata;
  logic [NR-1:0]      decd;
  logic [DW-1:0]      dout;
  logic               dout_vld;
  logic               err;
  logic               irq;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_reg [NR];
  logic [31:0] m_dout;
  logic        m_vld;
  logic        m_err;
  logic        m_irq;

  csr_bank #(
    .DWIDTH   (DW),
    .NUM_REG  (NR),
    .ALINES   (AL),
    .RST_VAL  (RV),
    .RO_MASK  (ROM),
    .W1C_MASK (W1M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .din      (din),
    .be       (be),
    .dfbck    (dfbck),
    .evt      (evt),
    .regdata  (regdata),
    .decd     (decd),
    .dout     (dout),
    .dout_vld (dout_vld),
    .err      (err),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // 0 = RW, 1 = RO, 2 = W1C
  function automatic int kind(input int i);
    if (ROM[i]) return 1;
    if (W1M[i]) return 2;
    return 0;
  endfunction

  task automatic tick();
    logic [31:0] nr [NR];
    logic [31:0] bm;
    logic [31:0] nd;
    logic [NR-1:0] ed;
    logic nv, ne, ni;
    int a;
    bit hit;
    #1;
    a   = int'(addr);
    hit = a < NR;
    ed  = '0;
    for (int i = 0; i < NR; i++) ed[i] = cs && (a == i);
    chk("decd", 32'(decd), 32'(ed));
    bm = '0;
    for (int k = 0; k < BE_W; k++) if (be[k]) bm |= 32'hFF << (8 * k);
    ni = 1'b0;
    for (int i = 0; i < NR; i++) begin
      nr[i] = m_reg[i];
      if (kind(i) == 2) begin
        ni = ni | (m_reg[i] != 0);
        if (cs && wr && a == i) nr[i] = nr[i] & ~(din & bm);
        nr[i] = nr[i] | evt[i*DW +: DW];
      end else if (kind(i) == 0 && cs && wr && a == i) begin
        nr[i] = (m_reg[i] & ~bm) | (din & bm);
      end
    end
`ifndef CSR_BANK_IRQ_EN
    ni = 1'b0;
`endif
    nv = cs && rd;
    nd = m_dout;
    if (nv) begin
      if (!hit)              nd = '0;
      else if (kind(a) == 1) nd = dfbck[a*DW +: DW];
      else                   nd = m_reg[a];
    end
    ne = cs && (((wr || rd) && !hit) || (wr && hit && kind(a) == 1));
    if (rst) begin
      for (int i = 0; i < NR; i++) nr[i] = RV[i*DW +: DW];
      nd = '0;
      nv = 1'b0;
      ne = 1'b0;
      ni = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) m_reg[i] = nr[i];
    m_dout = nd;
    m_vld  = nv;
    m_err  = ne;
    m_irq  = ni;
    for (int i = 0; i < NR; i++)
      chk($sformatf("reg%0d", i), regdata[i*DW +: DW], m_reg[i]);
    chk("dout", dout, m_dout);
    chk("dout_vld", 32'(dout_vld), 32'(m_vld));
    chk("err", 32'(err), 32'(m_err));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic drv(input logic c, input logic w, input logic r,
                     input int a, input logic [31:0] d,
                     input logic [3:0] b);
    cs   = c;
    wr   = w;
    rd   = r;
    addr = AL'(a);
    din  = d;
    be   = b;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_irq  = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_reg1", regdata[63:32], 32'h5AA55AA5);
    chk("t1_reg0", regdata[31:0], 32'h0);
    drv(1, 0, 1, 1, 0, 0);
    tick();
    chk("t1_dout", dout, 32'h5AA55AA5);
    chk("t1_vld", 32'(dout_vld), 32'd1);
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_vld_end", 32'(dout_vld), 32'd0);

    drv(1, 1, 0, 2, 32'h11223344, 4'b0101);
    tick();
    chk("t2_reg2", regdata[95:64], 32'h00220044);

    drv(0, 0, 0, 0, 0, 0);
    evt[3*DW +: DW] = 32'h81;
    tick();
    evt = '0;
    chk("t3_set", regdata[127:96], 32'h81);
    drv(1, 1, 0, 3, 32'h01, 4'hF);
    evt[3*DW +: DW] = 32'h01;
    tick();
    evt = '0;
    chk("t3_setwins", regdata[127:96], 32'h81);
`ifdef CSR_BANK_IRQ_EN
    chk("t3_irq", 32'(irq), 32'd1);
`endif
    drv(1, 1, 0, 3, 32'h81, 4'hF);
    tick();
    chk("t3_clr", regdata[127:96], 32'h0);
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_irq_off", 32'(irq), 32'd0);

    dfbck[4*DW +: DW] = 32'hCAFE0001;
    drv(1, 1, 0, 4, 32'hFFFFFFFF, 4'hF);
    tick();
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_reg4", regdata[159:128], 32'h0);
    drv(1, 0, 1, 4, 0, 0);
    tick();
    chk("t4_dout", dout, 32'hCAFE0001);
    chk("t4_noerr", 32'(err), 32'd0);

    drv(1, 0, 1, 20, 0, 0);
    tick();
    chk("t5_dout", dout, 32'h0);
    chk("t5_vld", 32'(dout_vld), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    drv(0, 1, 1, 2, 32'hDEAD, 4'hF);
    tick();
    chk("t5_cs0_vld", 32'(dout_vld), 32'd0);
    chk("t5_cs0_err", 32'(err), 32'd0);
    chk("t5_cs0_reg2", regdata[95:64], 32'h00220044);

    drv(1, 1, 0, 2, 32'h5, 4'hF);
    tick();
    drv(1, 1, 1, 2, 32'h9, 4'hF);
    tick();
    chk("t6_dout", dout, 32'h5);
    chk("t6_reg2", regdata[95:64], 32'h9);
    drv(1, 0, 1, 2, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_vld", 32'(dout_vld), 32'd0);
    chk("t6_rst_reg2", regdata[95:64], 32'h0);
    chk("t6_rst_reg1", regdata[63:32], 32'h5AA55AA5);

    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drv($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 23)), $urandom,
          4'($urandom_range(0, 15)));
      for (int i = 0; i < NR; i++) begin
        dfbck[i*DW +: DW] = $urandom;
        evt[i*DW +: DW]   = $urandom & $urandom & $urandom & $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
